time_counter: RTL

- Timekeeping register stage directly downstream of time_generator; consumes its one_minute pulse and holds current time of day as four BCD digits, HH:MM, 24-hour format.
- Accepts a user time-set load, validates it, and returns reset_count to time_generator so second/minute phase restarts aligned to the new time.
- Digit outputs feed the display driver and alarm comparator.

---
 rtl/clock_pkg.sv | 32 +++
 rtl/bcd_time_incr.sv | 37 +++
 rtl/time_counter.sv | 91 +++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared timekeeping definitions: BCD digit limits, the HH:MM time word
// used by the counter, alarm comparator and display, and a validity check.
package clock_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [3:0] MAX_MS_HR       = 4'd2;
  localparam logic [3:0] MAX_LS_HR_AT_20 = 4'd3;
  localparam logic [3:0] MAX_MS_MIN      = 4'd5;
  localparam logic [3:0] MAX_LS_DIG      = 4'd9;

  // 16-bit HH:MM time, four BCD digits, most significant digit first
  typedef struct packed {
    logic [DIGIT_W-1:0] ms_hr;
    logic [DIGIT_W-1:0] ls_hr;
    logic [DIGIT_W-1:0] ms_min;
    logic [DIGIT_W-1:0] ls_min;
  } bcd_time_t;

  // True when t is a legal 24-hour time (00:00 .. 23:59)
  function automatic logic time_is_valid(input bcd_time_t t);
    logic ok;
    ok = (t.ms_hr <= MAX_MS_HR) && (t.ms_min <= MAX_MS_MIN) && (t.ls_min <= MAX_LS_DIG);
    if (t.ms_hr == MAX_MS_HR) begin
      ok = ok && (t.ls_hr <= MAX_LS_HR_AT_20);
    end else begin
      ok = ok && (t.ls_hr <= MAX_LS_DIG);
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_time_incr.sv
// Combinational next-minute function on a BCD HH:MM time.
// wrap is raised when the input is 23:59 and the result rolls to 00:00.
module bcd_time_incr
  import clock_pkg::*;
(
  input  bcd_time_t cur,
  output bcd_time_t nxt,
  output logic      wrap
);

  // BCD carry chain: minutes units -> minutes tens -> hours
  always_comb begin
    nxt  = cur;
    wrap = 1'b0;
    if (cur.ls_min == MAX_LS_DIG) begin
      nxt.ls_min = 4'd0;
      if (cur.ms_min == MAX_MS_MIN) begin
        nxt.ms_min = 4'd0;
        if ((cur.ms_hr == MAX_MS_HR) && (cur.ls_hr == MAX_LS_HR_AT_20)) begin
          nxt.ms_hr = 4'd0;
          nxt.ls_hr = 4'd0;
          wrap      = 1'b1;
        end else if (cur.ls_hr == MAX_LS_DIG) begin
          nxt.ls_hr = 4'd0;
          nxt.ms_hr = cur.ms_hr + 4'd1;
        end else begin
          nxt.ls_hr = cur.ls_hr + 4'd1;
        end
      end else begin
        nxt.ms_min = cur.ms_min + 4'd1;
      end
    end else begin
      nxt.ls_min = cur.ls_min + 4'd1;
    end
  end

endmodule

// File: rtl/time_counter.sv
// Time-of-day register stage: advances HH:MM on each one_minute cycle,
// accepts validated time-set loads, and reports load/wrap events as
// single-cycle pulses. Priority: reset > load_new_time > one_minute.
module time_counter
  import clock_pkg::*;
#(
  parameter logic [7:0] RESET_HH = 8'h00,
  parameter logic [7:0] RESET_MM = 8'h00
)
(
  input  logic       clk,
  input  logic       reset,
  input  logic       one_minute,
  input  logic       load_new_time,
  input  logic [3:0] new_time_ms_hr,
  input  logic [3:0] new_time_ls_hr,
  input  logic [3:0] new_time_ms_min,
  input  logic [3:0] new_time_ls_min,
  output logic [3:0] current_time_ms_hr,
  output logic [3:0] current_time_ls_hr,
  output logic [3:0] current_time_ms_min,
  output logic [3:0] current_time_ls_min,
  output logic       reset_count,
  output logic       load_err,
  output logic       day_wrap
);

  localparam bcd_time_t RESET_TIME = {RESET_HH, RESET_MM};

  bcd_time_t time_r;
  bcd_time_t time_nxt_s;
  bcd_time_t incr_s;
  bcd_time_t new_time_s;
  logic      wrap_s;
  logic      reset_count_r, reset_count_nxt_s;
  logic      load_err_r,    load_err_nxt_s;
  logic      day_wrap_r,    day_wrap_nxt_s;

  assign new_time_s = {new_time_ms_hr, new_time_ls_hr, new_time_ms_min, new_time_ls_min};

  bcd_time_incr u_incr (
    .cur  (time_r),
    .nxt  (incr_s),
    .wrap (wrap_s)
  );

  // Next-state selection: a load (good or bad) always swallows a coincident tick
  always_comb begin
    time_nxt_s        = time_r;
    reset_count_nxt_s = 1'b0;
    load_err_nxt_s    = 1'b0;
    day_wrap_nxt_s    = 1'b0;
    if (load_new_time) begin
      if (time_is_valid(new_time_s)) begin
        time_nxt_s        = new_time_s;
        reset_count_nxt_s = 1'b1;
      end else begin
        load_err_nxt_s    = 1'b1;
      end
    end else if (one_minute) begin
      time_nxt_s     = incr_s;
      day_wrap_nxt_s = wrap_s;
    end else begin
      time_nxt_s = time_r;
    end
  end

  // State and pulse registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      time_r        <= RESET_TIME;
      reset_count_r <= 1'b0;
      load_err_r    <= 1'b0;
      day_wrap_r    <= 1'b0;
    end else begin
      time_r        <= time_nxt_s;
      reset_count_r <= reset_count_nxt_s;
      load_err_r    <= load_err_nxt_s;
      day_wrap_r    <= day_wrap_nxt_s;
    end
  end

  assign current_time_ms_hr  = time_r.ms_hr;
  assign current_time_ls_hr  = time_r.ls_hr;
  assign current_time_ms_min = time_r.ms_min;
  assign current_time_ls_min = time_r.ls_min;
  assign reset_count         = reset_count_r;
  assign load_err            = load_err_r;
  assign day_wrap            = day_wrap_r;

endmodule
